// File: rtl/deskew_pkg.sv
// Shared types and defaults for the multi-lane PCS deskew block.
package deskew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_ALIGNED = 2'd2,
    ST_ERR     = 2'd3
  } deskew_state_e;

  localparam int DEF_LANE_N           = 4;
  localparam int DEF_BLOCK_W          = 66;
  localparam int DEF_MAX_SKEW_BLOCK_N = 16;

  // Pointer width for a circular buffer, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/deskew_lane_buf.sv
// Per-lane circular block buffer. Each entry stores one block plus its
// alignment-marker tag. Reading the slot being written this cycle returns
// the incoming block, so a zero-delay lane sees the current block.
module deskew_lane_buf
  import deskew_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int DEPTH   = DEF_MAX_SKEW_BLOCK_N,
  parameter int PTR_W   = ptr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic               wr_am,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [BLOCK_W-1:0] rd_data,
  output logic               rd_am
);

  logic [BLOCK_W:0] mem_r [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr] <= {wr_am, wr_data};
    end
  end

  // Read port with write-through for the slot currently being written.
  always_comb begin
    if (wr_en && (rd_ptr == wr_ptr)) begin
      {rd_am, rd_data} = {wr_am, wr_data};
    end else begin
      {rd_am, rd_data} = mem_r[rd_ptr];
    end
  end

endmodule

// File: rtl/deskew_multi_lane_rx.sv
// Multi-lane receive deskew: measures alignment-marker arrival skew across
// lanes, then reads each lane's circular buffer at a per-lane delay so all
// lanes leave aligned. Optional feature macro DESKEW_AM_DROP_EN suppresses
// valid_o for aligned marker blocks.
module deskew_multi_lane_rx
  import deskew_pkg::*;
#(
  parameter int LANE_N           = DEF_LANE_N,
  parameter int BLOCK_W          = DEF_BLOCK_W,
  parameter int MAX_SKEW_BLOCK_N = DEF_MAX_SKEW_BLOCK_N,
  parameter int SKEW_CNT_W       = $clog2(MAX_SKEW_BLOCK_N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic                      lock_lost_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic                      deskew_done_o,
  output logic                      skew_err_o
);

  localparam int PTR_W = ptr_width(MAX_SKEW_BLOCK_N);
  localparam int SUM_W = SKEW_CNT_W + PTR_W + 1;
  localparam logic [SKEW_CNT_W-1:0] MAX_CNT  = SKEW_CNT_W'(MAX_SKEW_BLOCK_N);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(MAX_SKEW_BLOCK_N - 1);
  localparam logic [SUM_W-1:0]      DEPTH_S  = SUM_W'(MAX_SKEW_BLOCK_N);

  deskew_state_e            state_r;
  logic [SKEW_CNT_W-1:0]    cnt_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [LANE_N-1:0]        rec_r;
  logic [SKEW_CNT_W-1:0]    arr_r   [LANE_N];
  logic [SKEW_CNT_W-1:0]    delay_r [LANE_N];

  logic [PTR_W-1:0]         rd_ptr_s [LANE_N];
  logic [LANE_N*BLOCK_W-1:0] rd_data_s;
  logic [LANE_N-1:0]        rd_am_s;
  logic                     tags_eq_s;
  logic [SKEW_CNT_W-1:0]    cnt_nx_s;
  logic [LANE_N-1:0]        rec_nx_s;
  logic [SKEW_CNT_W-1:0]    arr_nx_s [LANE_N];

  // Buffer read address: write pointer minus lane delay, modulo depth.
  function automatic logic [PTR_W-1:0] rd_addr(input logic [PTR_W-1:0] wp,
                                               input logic [SKEW_CNT_W-1:0] dly);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(wp) + DEPTH_S - SUM_W'(dly);
    if (sum >= DEPTH_S) begin
      sum = sum - DEPTH_S;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    assign rd_ptr_s[l] = rd_addr(wr_ptr_r, delay_r[l]);

    deskew_lane_buf #(
      .BLOCK_W (BLOCK_W),
      .DEPTH   (MAX_SKEW_BLOCK_N),
      .PTR_W   (PTR_W)
    ) u_buf (
      .clk     (clk),
      .wr_en   (valid_i),
      .wr_ptr  (wr_ptr_r),
      .wr_data (data_i[l*BLOCK_W +: BLOCK_W]),
      .wr_am   (am_v_i[l]),
      .rd_ptr  (rd_ptr_s[l]),
      .rd_data (rd_data_s[l*BLOCK_W +: BLOCK_W]),
      .rd_am   (rd_am_s[l])
    );
  end

  assign tags_eq_s = (&rd_am_s) | ~(|rd_am_s);

`ifdef DESKEW_AM_DROP_EN
  logic am_all_s;
  assign am_all_s = &rd_am_s;
`endif

  // Skew search bookkeeping for the current valid cycle.
  always_comb begin
    cnt_nx_s = cnt_r + SKEW_CNT_W'(1);
    rec_nx_s = rec_r | am_v_i;
    for (int l = 0; l < LANE_N; l++) begin
      if (am_v_i[l] && !rec_r[l]) begin
        arr_nx_s[l] = cnt_nx_s;
      end else begin
        arr_nx_s[l] = arr_r[l];
      end
    end
  end

  // Shared write pointer, advancing on every valid block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
    end else if (valid_i) begin
      if (wr_ptr_r == PTR_LAST) begin
        wr_ptr_r <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Deskew FSM with registered outputs. Lock loss overrides everything;
  // the error state always lasts a single cycle so the pulse stays one wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      rec_r         <= '0;
      for (int l = 0; l < LANE_N; l++) begin
        arr_r[l]   <= '0;
        delay_r[l] <= '0;
      end
      valid_o       <= 1'b0;
      data_o        <= '0;
      deskew_done_o <= 1'b0;
      skew_err_o    <= 1'b0;
    end else if (lock_lost_i) begin
      state_r       <= ST_IDLE;
      rec_r         <= '0;
      valid_o       <= 1'b0;
      deskew_done_o <= 1'b0;
      skew_err_o    <= 1'b0;
    end else if (state_r == ST_ERR) begin
      state_r    <= ST_IDLE;
      skew_err_o <= 1'b0;
    end else if (valid_i) begin
      case (state_r)
        ST_IDLE: begin
          if (|am_v_i) begin
            cnt_r <= '0;
            for (int l = 0; l < LANE_N; l++) begin
              arr_r[l]   <= '0;
              delay_r[l] <= '0;
            end
            if (&am_v_i) begin
              state_r       <= ST_ALIGNED;
              rec_r         <= '1;
              deskew_done_o <= 1'b1;
            end else begin
              state_r <= ST_SEARCH;
              rec_r   <= am_v_i;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEARCH: begin
          if (cnt_nx_s >= MAX_CNT) begin
            state_r    <= ST_ERR;
            skew_err_o <= 1'b1;
          end else begin
            cnt_r <= cnt_nx_s;
            rec_r <= rec_nx_s;
            for (int l = 0; l < LANE_N; l++) begin
              arr_r[l] <= arr_nx_s[l];
            end
            if (&rec_nx_s) begin
              // The last lane arrives now, so the current count is the max.
              state_r       <= ST_ALIGNED;
              deskew_done_o <= 1'b1;
              for (int l = 0; l < LANE_N; l++) begin
                delay_r[l] <= cnt_nx_s - arr_nx_s[l];
              end
            end else begin
              state_r <= ST_SEARCH;
            end
          end
        end
        ST_ALIGNED: begin
          if (!tags_eq_s) begin
            state_r       <= ST_ERR;
            skew_err_o    <= 1'b1;
            valid_o       <= 1'b0;
            deskew_done_o <= 1'b0;
          end else begin
            data_o <= rd_data_s;
`ifdef DESKEW_AM_DROP_EN
            valid_o <= ~am_all_s;
`else
            valid_o <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_deskew_multi_lane_rx.sv
// Directed self-checking bench for deskew_multi_lane_rx (default parameters).
module tb_deskew_multi_lane_rx;
  import deskew_pkg::*;

  localparam int LANE_N  = 4;
  localparam int BLOCK_W = 66;
  localparam int DW      = LANE_N * BLOCK_W;
  localparam int A [4] = '{0, 3, 5, 2};   // AM arrival counts per lane
  localparam int D [4] = '{5, 2, 0, 3};   // resulting lane delays

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic [3:0]    am_v_i;
  logic          lock_lost_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          deskew_done_o;
  logic          skew_err_o;

  int errors = 0;
  int checks = 0;
  int gn = 0;

  always #5 clk = ~clk;

  deskew_multi_lane_rx #(
    .LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .MAX_SKEW_BLOCK_N(16)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .am_v_i(am_v_i),
    .lock_lost_i(lock_lost_i), .data_i(data_i), .valid_o(valid_o),
    .data_o(data_o), .deskew_done_o(deskew_done_o), .skew_err_o(skew_err_o)
  );

  function automatic logic [BLOCK_W-1:0] mk(input int l, input int n);
    logic [15:0] nn;
    logic [3:0]  ll;
    nn = n[15:0];
    ll = l[3:0];
    return {2'b10, 44'd0, nn, ll};
  endfunction

  function automatic logic [DW-1:0] pack4(input int n0, input int n1, input int n2, input int n3);
    return {mk(3, n3), mk(2, n2), mk(1, n1), mk(0, n0)};
  endfunction

  // One clock: drive inputs, step past the rising edge, then outputs are stable.
  task automatic cyc(input logic v, input logic [3:0] am, input logic ll);
    valid_i = v;
    am_v_i = am;
    lock_lost_i = ll;
    for (int l = 0; l < LANE_N; l++) data_i[l*BLOCK_W +: BLOCK_W] = mk(l, gn);
    @(posedge clk);
    #1;
    if (v) gn++;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_i = 1'b0; am_v_i = 4'd0; lock_lost_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    checks++; if (deskew_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", deskew_done_o); end
    checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", skew_err_o); end
    checks++; if (data_o !== {DW{1'b0}}) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_r, ST_IDLE); end
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (deskew_done_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL idle_no_am: got done=%0b valid=%0b want 0 0", deskew_done_o, valid_o); end
  endtask

  task automatic test_same_cycle;
    int n;
    n = gn;
    cyc(1'b1, 4'hF, 1'b0);
    checks++; if (deskew_done_o !== 1'b1) begin errors++; $display("FAIL same_done: got %0b want 1", deskew_done_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL same_valid0: got %0b want 0", valid_o); end
    for (int i = 1; i <= 2; i++) begin
      cyc(1'b1, 4'd0, 1'b0);
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL same_valid%0d: got %0b want 1", i, valid_o); end
      checks++; if (data_o !== pack4(n+i, n+i, n+i, n+i)) begin errors++; $display("FAIL same_data%0d: got %h want %h", i, data_o, pack4(n+i, n+i, n+i, n+i)); end
    end
  endtask

  task automatic test_inject_single_am;
    cyc(1'b1, 4'b0010, 1'b0);
    checks++; if (skew_err_o !== 1'b1) begin errors++; $display("FAIL inject_err: got %0b want 1", skew_err_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL inject_valid: got %0b want 0", valid_o); end
    checks++; if (deskew_done_o !== 1'b0) begin errors++; $display("FAIL inject_done: got %0b want 0", deskew_done_o); end
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL inject_pulse: got %0b want 0", skew_err_o); end
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL inject_state: got %0d want %0d", dut.state_r, ST_IDLE); end
  endtask

  // AMs at counts 0,3,5,2 then a second marker round eight blocks later.
  task automatic test_skew(input bit gap);
    int n0;
    logic [3:0] am;
    logic exp_v;
    n0 = gn;
    for (int k = 0; k <= 14; k++) begin
      am = 4'd0;
      for (int l = 0; l < 4; l++) if (k == A[l] || k == 8 + A[l]) am[l] = 1'b1;
      cyc(1'b1, am, 1'b0);
      if (gap && k == 3) begin
        repeat (3) cyc(1'b0, 4'b0100, 1'b0);
        checks++; if (dut.cnt_r !== 5'd3) begin errors++; $display("FAIL gap_cnt: got %0d want 3", dut.cnt_r); end
        checks++; if (dut.rec_r !== 4'b1011) begin errors++; $display("FAIL gap_rec: got %b want 1011", dut.rec_r); end
        checks++; if (dut.arr_r[1] !== 5'd3) begin errors++; $display("FAIL gap_arr1: got %0d want 3", dut.arr_r[1]); end
      end
      if (k == 4) begin
        checks++; if (deskew_done_o !== 1'b0) begin errors++; $display("FAIL skew_done_early g%0d: got %0b want 0", gap, deskew_done_o); end
      end
      if (k == 5) begin
        checks++; if (deskew_done_o !== 1'b1) begin errors++; $display("FAIL skew_done g%0d: got %0b want 1", gap, deskew_done_o); end
        for (int l = 0; l < 4; l++) begin
          checks++; if (dut.delay_r[l] !== 5'(D[l])) begin errors++; $display("FAIL skew_delay%0d g%0d: got %0d want %0d", l, gap, dut.delay_r[l], D[l]); end
        end
      end
      if (k >= 6) begin
        exp_v = 1'b1;
`ifdef DESKEW_AM_DROP_EN
        if (k == 13) exp_v = 1'b0;
`endif
        checks++; if (valid_o !== exp_v || skew_err_o !== 1'b0) begin errors++; $display("FAIL skew_valid k%0d g%0d: got v=%0b e=%0b want v=%0b e=0", k, gap, valid_o, skew_err_o, exp_v); end
        checks++; if (data_o !== pack4(n0+k-D[0], n0+k-D[1], n0+k-D[2], n0+k-D[3])) begin errors++; $display("FAIL skew_data k%0d g%0d: got %h want %h", k, gap, data_o, pack4(n0+k-D[0], n0+k-D[1], n0+k-D[2], n0+k-D[3])); end
      end
    end
    checks++; if (data_o[65:0] !== mk(0, n0+9)) begin errors++; $display("FAIL skew_lane0_last: got %h want %h", data_o[65:0], mk(0, n0+9)); end
    cyc(1'b1, 4'd0, 1'b1);
    checks++; if (deskew_done_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL skew_exit: got done=%0b valid=%0b want 0 0", deskew_done_o, valid_o); end
  endtask

  task automatic test_timeout;
    cyc(1'b1, 4'b0111, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b1, 4'd0, 1'b0);
      checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL tmo_early k%0d: got %0b want 0", k, skew_err_o); end
    end
    checks++; if (dut.state_r !== ST_SEARCH) begin errors++; $display("FAIL tmo_search: got %0d want %0d", dut.state_r, ST_SEARCH); end
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (skew_err_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b want 1", skew_err_o); end
    checks++; if (deskew_done_o !== 1'b0) begin errors++; $display("FAIL tmo_done: got %0b want 0", deskew_done_o); end
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %0b want 0", skew_err_o); end
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL tmo_idle: got %0d want %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_lock_final;
    cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b1100, 1'b1);
    checks++; if (deskew_done_o !== 1'b0) begin errors++; $display("FAIL lock_done: got %0b want 0", deskew_done_o); end
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL lock_state: got %0d want %0d", dut.state_r, ST_IDLE); end
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (deskew_done_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL lock_after: got done=%0b valid=%0b want 0 0", deskew_done_o, valid_o); end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ares_pre: got %0b want 1", valid_o); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || deskew_done_o !== 1'b0) begin errors++; $display("FAIL ares_out: got valid=%0b done=%0b want 0 0", valid_o, deskew_done_o); end
    checks++; if (data_o !== {DW{1'b0}}) begin errors++; $display("FAIL ares_data: got %h want 0", data_o); end
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL ares_state: got %0d want %0d", dut.state_r, ST_IDLE); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 4'd0, 1'b0);
    checks++; if (valid_o !== 1'b0 || deskew_done_o !== 1'b0) begin errors++; $display("FAIL ares_after: got valid=%0b done=%0b want 0 0", valid_o, deskew_done_o); end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_inject_single_am();
    test_skew(1'b0);
    test_skew(1'b1);
    test_timeout();
    test_lock_final();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
